// File: rtl/convolution_procesor_pkg.sv
// convolution_procesor_pkg: shared FSM states and default address width
package convolution_procesor_pkg;
  localparam int ADDR_WIDTH_DEF = 5;
  typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, WRITE, DONE} state_t;
endpackage

// File: rtl/convolution_procesor_gateAND.sv
// convolution_procesor_gateAND: combines the two range flags into one valid
module convolution_procesor_gateAND (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/convolution_procesor_control.sv
// convolution_procesor_control: sequences X/Y reads, MAC and Z writes for 1-D convolution
module convolution_procesor_control
  import convolution_procesor_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] sizeX,
  input  logic [ADDR_WIDTH-1:0] sizeY,
  output logic [ADDR_WIDTH-1:0] memX_addr,
  output logic [ADDR_WIDTH-1:0] memY_addr,
  output logic [ADDR_WIDTH:0]   memZ_addr,
  output logic                  memZ_we,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  busy,
  output logic                  done
);
  localparam int W = ADDR_WIDTH + 2;
  state_t state;
  logic [ADDR_WIDTH-1:0] sx, sy, i;
  logic [ADDR_WIDTH:0] k;
  logic signed [W-1:0] diff;
  logic [W-1:0] k_last;
  logic lo_ok, hi_ok, in_range, pair_valid;
  assign diff = $signed({1'b0, k}) - $signed({2'b00, i});
  assign lo_ok = !diff[W-1];
  assign hi_ok = diff < $signed({2'b00, sy});
  assign k_last = W'(sx) + W'(sy) - W'(2);
  convolution_procesor_gateAND u_and (.a(lo_ok), .b(hi_ok), .y(in_range));
  assign pair_valid = (state == READ) && in_range;
  assign memX_addr = i;
  assign memY_addr = diff[ADDR_WIDTH-1:0];
  assign memZ_addr = k;
  assign memZ_we = state == WRITE;
  assign acc_clr = state == CLEAR;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // acc_en is the pair flag delayed one cycle to line up with memory read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sx <= '0;
      sy <= '0;
      i <= '0;
      k <= '0;
      acc_en <= 1'b0;
    end else begin
      acc_en <= pair_valid;
      case (state)
        IDLE: if (start) begin
          sx <= sizeX;
          sy <= sizeY;
          k <= '0;
          state <= (sizeX == '0 || sizeY == '0) ? DONE : CLEAR;
        end
        CLEAR: begin
          i <= '0;
          state <= READ;
        end
        READ: begin
          i <= i + ADDR_WIDTH'(1);
          if (i == sx - ADDR_WIDTH'(1)) state <= DRAIN;
        end
        DRAIN: state <= WRITE;
        WRITE: if (W'(k) == k_last) state <= DONE;
        else begin
          k <= k + 1'b1;
          state <= CLEAR;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_convolution_procesor_control.sv
// tb_convolution_procesor_control: scoreboard bench with a behavioural MAC and memories
module tb_convolution_procesor_control;
  localparam int AW = 5;
  logic clk = 0, rst_n = 0, start = 0;
  logic [AW-1:0] sizeX = '0, sizeY = '0, memX_addr, memY_addr;
  logic [AW:0] memZ_addr;
  logic memZ_we, acc_clr, acc_en, busy, done;

  convolution_procesor_control #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sizeX(sizeX), .sizeY(sizeY),
    .memX_addr(memX_addr), .memY_addr(memY_addr), .memZ_addr(memZ_addr),
    .memZ_we(memZ_we), .acc_clr(acc_clr), .acc_en(acc_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int xm[32], ym[32];
  int xd = 0, yd = 0, acc = 0;
  always @(posedge clk) begin
    xd <= xm[memX_addr];
    yd <= ym[memY_addr];
    acc <= acc_clr ? 0 : acc_en ? acc + xd * yd : acc;
  end

  typedef struct {int addr; int data;} wr_t;
  wr_t exp_wr[$];
  wr_t e;
  int exp_lat[$];
  int errors = 0, checks = 0, cyc = 0, acc_at = 0;
  int wr_cnt = 0, done_cnt = 0, busy_cnt = 0, en_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (acc_en) en_cnt++;
    if (rst_n && start && !busy) acc_at = cyc;
    if (memZ_we) begin
      wr_cnt++;
      if (exp_wr.size() == 0) chk("unexpected_write_addr", int'(memZ_addr), -1);
      else begin
        e = exp_wr.pop_front();
        chk("z_addr", int'(memZ_addr), e.addr);
        chk("z_data", acc, e.data);
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_lat.size() == 0) chk("unexpected_done_latency", cyc - acc_at, -1);
      else chk("done_latency", cyc - acc_at, exp_lat.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int sx, input int sy);
    sizeX = AW'(sx);
    sizeY = AW'(sy);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = done;
    for (int n = 0; n < bound && !seen; n++) begin
      tick();
      seen = done;
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic push(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_memX_addr"}, int'(memX_addr), 0);
    chk({tag, "_memY_addr"}, int'(memY_addr), 0);
    chk({tag, "_memZ_addr"}, int'(memZ_addr), 0);
    chk({tag, "_memZ_we"}, int'(memZ_we), 0);
    chk({tag, "_acc_clr"}, int'(acc_clr), 0);
    chk({tag, "_acc_en"}, int'(acc_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic load_small();
    xm[0] = 1; xm[1] = 2; xm[2] = 3;
    ym[0] = 4; ym[1] = 5;
  endtask

  initial begin
    int b0, e0, w0, d0;
    int m;
    for (int n = 0; n < 32; n++) begin
      xm[n] = 0;
      ym[n] = 0;
    end
    tick();
    tick();
    chk_idle_outputs("reset");
    rst_n = 1;
    // 3x2 convolution
    load_small();
    push(0, 4); push(1, 13); push(2, 22); push(3, 15);
    exp_lat.push_back(25);
    go(3, 2);
    wait_done(100);
    tick();
    // 1x1 convolution
    xm[0] = 7; ym[0] = 6;
    push(0, 42);
    exp_lat.push_back(5);
    go(1, 1);
    wait_done(20);
    tick();
    // zero size: immediate done, nothing else
    b0 = busy_cnt; e0 = en_cnt; w0 = wr_cnt;
    exp_lat.push_back(1);
    go(0, 4);
    wait_done(5);
    tick();
    chk("zero_busy_cycles", busy_cnt - b0, 1);
    chk("zero_acc_en", en_cnt - e0, 0);
    chk("zero_writes", wr_cnt - w0, 0);
    // start held high through a run, sizes changed while busy
    load_small();
    w0 = wr_cnt; d0 = done_cnt;
    push(0, 4); push(1, 13); push(2, 22); push(3, 15);
    exp_lat.push_back(25);
    sizeX = 3; sizeY = 2; start = 1;
    tick();
    sizeX = 1; sizeY = 1;
    wait_done(100);
    start = 0;
    tick();
    tick();
    chk("held_busy_after", int'(busy), 0);
    chk("held_writes", wr_cnt - w0, 4);
    chk("held_dones", done_cnt - d0, 1);
    push(0, 4); push(1, 13); push(2, 22); push(3, 15);
    exp_lat.push_back(25);
    go(3, 2);
    wait_done(100);
    tick();
    // reset during READ of k=2
    w0 = wr_cnt;
    push(0, 4); push(1, 13);
    go(3, 2);
    m = 0;
    while (wr_cnt - w0 < 2 && m < 100) begin
      tick();
      m++;
    end
    chk("rst_reach_k2", wr_cnt - w0, 2);
    m = 0;
    while (!acc_clr && m < 10) begin
      tick();
      m++;
    end
    chk("rst_clear_k2", int'(acc_clr), 1);
    tick();
    tick();
    rst_n = 0;
    #1;
    chk_idle_outputs("midrst");
    tick();
    tick();
    rst_n = 1;
    d0 = done_cnt;
    repeat (40) tick();
    chk("rst_writes", wr_cnt - w0, 2);
    chk("rst_dones", done_cnt - d0, 0);
    chk("rst_busy", int'(busy), 0);
    // full-size 31x31 all ones
    for (int n = 0; n < 32; n++) begin
      xm[n] = 1;
      ym[n] = 1;
    end
    for (int k = 0; k <= 60; k++) begin
      m = k + 1;
      if (61 - k < m) m = 61 - k;
      if (31 < m) m = 31;
      push(k, m);
    end
    exp_lat.push_back(61 * 34 + 1);
    w0 = wr_cnt;
    go(31, 31);
    wait_done(3000);
    tick();
    chk("big_writes", wr_cnt - w0, 61);
    chk("exp_wr_left", exp_wr.size(), 0);
    chk("exp_lat_left", exp_lat.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
